// File: rtl/mux_share_arbiter.sv
// Round-robin owner of a shared 2:1 data mux feeding a registered valid/ready output stage.
// Define MUX_SHARE_ARB_STATS_EN to add per-side accepted-beat counters (cnt_a, cnt_b).
module mux_share_arbiter #(
    parameter int WIDTH    = 5,
    parameter int MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_a,
    input  logic [WIDTH-1:0] a_data,
    output logic             gnt_a,
    input  logic             req_b,
    input  logic [WIDTH-1:0] b_data,
    output logic             gnt_b,
    output logic             sel,
    output logic [WIDTH-1:0] y,
    output logic             y_valid,
    input  logic             y_ready
`ifdef MUX_SHARE_ARB_STATS_EN
    ,
    output logic [15:0]      cnt_a,
    output logic [15:0]      cnt_b
`endif
);

    localparam int CW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [CW-1:0] HOLD_MAX = CW'(MAX_HOLD);

    typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;

    state_t        state, state_next;
    logic [CW-1:0] beat_cnt, beat_cnt_d, beat_cnt_acc;
    logic          last_owner_b, last_owner_b_d;
    logic          sel_d;
    logic          slot_free, xfer_a, xfer_b;
    logic          mine_req, other_req;

    always_comb begin
        slot_free      = !y_valid || y_ready;
        gnt_a          = (state == OWN_A) && slot_free;
        gnt_b          = (state == OWN_B) && slot_free;
        xfer_a         = req_a && gnt_a;
        xfer_b         = req_b && gnt_b;
        beat_cnt_acc   = beat_cnt;
        if ((xfer_a || xfer_b) && beat_cnt != HOLD_MAX)
            beat_cnt_acc = beat_cnt + CW'(1);
        mine_req       = (state == OWN_B) ? req_b : req_a;
        other_req      = (state == OWN_B) ? req_a : req_b;
        state_next     = state;
        beat_cnt_d     = beat_cnt_acc;
        last_owner_b_d = last_owner_b;
        sel_d          = sel;
        case (state)
            IDLE: begin
                // Contention in IDLE goes to whichever side did not own last.
                if (req_a && (!req_b || last_owner_b)) begin
                    state_next     = OWN_A;
                    last_owner_b_d = 1'b0;
                    beat_cnt_d     = '0;
                    sel_d          = 1'b0;
                end else if (req_b) begin
                    state_next     = OWN_B;
                    last_owner_b_d = 1'b1;
                    beat_cnt_d     = '0;
                    sel_d          = 1'b1;
                end
            end
            OWN_A, OWN_B: begin
                if (other_req && (!mine_req || beat_cnt_acc == HOLD_MAX)) begin
                    state_next     = (state == OWN_A) ? OWN_B : OWN_A;
                    last_owner_b_d = (state == OWN_A);
                    beat_cnt_d     = '0;
                    sel_d          = (state == OWN_A);
                end else if (!mine_req) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            beat_cnt     <= '0;
            last_owner_b <= 1'b1;
            sel          <= 1'b0;
            y            <= '0;
            y_valid      <= 1'b0;
        end else begin
            state        <= state_next;
            beat_cnt     <= beat_cnt_d;
            last_owner_b <= last_owner_b_d;
            sel          <= sel_d;
            if (xfer_a) begin
                y       <= a_data;
                y_valid <= 1'b1;
            end else if (xfer_b) begin
                y       <= b_data;
                y_valid <= 1'b1;
            end else if (y_ready) begin
                y_valid <= 1'b0;
            end
        end
    end

`ifdef MUX_SHARE_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_a <= '0;
            cnt_b <= '0;
        end else begin
            if (xfer_a && cnt_a != '1) cnt_a <= cnt_a + 16'd1;
            if (xfer_b && cnt_b != '1) cnt_b <= cnt_b + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mux_share_arbiter.sv
// Randomized and directed bench for mux_share_arbiter against an ownership/run-length model.
// Honors MUX_SHARE_ARB_STATS_EN to also check the beat counters.
module tb_mux_share_arbiter;
    localparam int WIDTH    = 5;
    localparam int MAX_HOLD = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req_a = 1'b0, req_b = 1'b0, y_ready = 1'b0;
    logic [WIDTH-1:0] a_data = '0, b_data = '0;
    logic             gnt_a, gnt_b, sel, y_valid;
    logic [WIDTH-1:0] y;
`ifdef MUX_SHARE_ARB_STATS_EN
    logic [15:0]      cnt_a, cnt_b;
`endif

    always #5 clk = ~clk;

    mux_share_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_a(req_a), .a_data(a_data), .gnt_a(gnt_a),
        .req_b(req_b), .b_data(b_data), .gnt_b(gnt_b),
        .sel(sel), .y(y), .y_valid(y_valid), .y_ready(y_ready)
`ifdef MUX_SHARE_ARB_STATS_EN
        , .cnt_a(cnt_a), .cnt_b(cnt_b)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;

    // Model: owner 0 = nobody, 1 = A, 2 = B; run = beats taken in current ownership.
    int m_owner, m_run, m_last, m_sel, m_y, m_yv, m_ca, m_cb;
    int e_ga, e_gb;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = 0; m_run = 0; m_last = 2; m_sel = 0;
        m_y = 0; m_yv = 0; m_ca = 0; m_cb = 0;
    endtask

    task automatic check_outputs();
        int slot;
        slot = (m_yv == 0 || y_ready) ? 1 : 0;
        e_ga = (m_owner == 1 && slot == 1) ? 1 : 0;
        e_gb = (m_owner == 2 && slot == 1) ? 1 : 0;
        chk("gnt_a", int'(gnt_a), e_ga);
        chk("gnt_b", int'(gnt_b), e_gb);
        chk("sel", int'(sel), m_sel);
        chk("y_valid", int'(y_valid), m_yv);
        chk("y", int'(y), m_y);
`ifdef MUX_SHARE_ARB_STATS_EN
        chk("cnt_a", int'(cnt_a), m_ca);
        chk("cnt_b", int'(cnt_b), m_cb);
`endif
    endtask

    task automatic model_step();
        int took_a, took_b, mine, other, run;
        if (!rst_n) begin
            model_reset();
            return;
        end
        took_a = (req_a && e_ga == 1) ? 1 : 0;
        took_b = (req_b && e_gb == 1) ? 1 : 0;
        if (took_a == 1) begin
            m_y = int'(a_data); m_yv = 1;
            if (m_ca < 65535) m_ca++;
        end else if (took_b == 1) begin
            m_y = int'(b_data); m_yv = 1;
            if (m_cb < 65535) m_cb++;
        end else if (y_ready) begin
            m_yv = 0;
        end
        if (m_owner == 0) begin
            int pick;
            pick = 0;
            if (req_a && req_b) pick = (m_last == 1) ? 2 : 1;
            else if (req_a) pick = 1;
            else if (req_b) pick = 2;
            if (pick != 0) begin
                m_owner = pick; m_last = pick; m_run = 0; m_sel = pick - 1;
            end
        end else begin
            mine  = (m_owner == 1) ? int'(req_a) : int'(req_b);
            other = (m_owner == 1) ? int'(req_b) : int'(req_a);
            run   = m_run + took_a + took_b;
            if (run > MAX_HOLD) run = MAX_HOLD;
            if (other == 1 && (mine == 0 || run == MAX_HOLD)) begin
                m_owner = 3 - m_owner; m_last = m_owner; m_run = 0; m_sel = m_owner - 1;
            end else if (mine == 0 && other == 0) begin
                m_owner = 0; m_run = run;
            end else begin
                m_run = run;
            end
        end
    endtask

    task automatic cycle(input logic ra, input logic rb, input logic [WIDTH-1:0] ad,
                         input logic [WIDTH-1:0] bd, input logic yr, input logic rs);
        @(negedge clk);
        req_a = ra; req_b = rb; a_data = ad; b_data = bd; y_ready = yr; rst_n = rs;
        #1;
        check_outputs();
        model_step();
    endtask

    localparam logic [WIDTH-1:0] DA = 5'b10110;
    localparam logic [WIDTH-1:0] DB = 5'b11001;

    initial begin
        logic [15:0] seq;
        int beats;
        logic ra, rb;

        model_reset();
        @(posedge clk);

        // Reset with both requesting
        cycle(1, 1, DA, DB, 1, 0);
        cycle(1, 1, DA, DB, 1, 0);
        chk("rst_gnt_a", int'(gnt_a), 0);
        chk("rst_gnt_b", int'(gnt_b), 0);
        chk("rst_y", int'(y), 0);
        chk("rst_sel", int'(sel), 0);

        // A alone
        cycle(1, 0, DA, DB, 1, 1);
        chk("a_first_no_gnt", int'(gnt_a), 0);
        cycle(1, 0, DA, DB, 1, 1);
        chk("a_gnt_latency", int'(gnt_a), 1);
        cycle(0, 0, DA, DB, 1, 1);
        chk("a_y", int'(y), 22);
        chk("a_y_valid", int'(y_valid), 1);
        chk("a_sel", int'(sel), 0);

        // Both requesting after reset: AAAABBBB repeating, A first
        cycle(0, 0, DA, DB, 1, 0);
        seq = '0; beats = 0;
        for (int i = 0; i < 17; i++) begin
            cycle(1, 1, DA, DB, 1, 1);
            if (gnt_a && req_a) begin seq = {seq[14:0], 1'b0}; beats++; end
            if (gnt_b && req_b) begin seq = {seq[14:0], 1'b1}; beats++; end
        end
        chk("rr_beats", beats, 16);
        chk("rr_pattern", int'(seq), 16'h0F0F);

        // Backpressure then release
        cycle(1, 1, DA, DB, 0, 1);
        chk("bp_gnt", int'(gnt_a | gnt_b), 0);
        cycle(1, 1, DA, DB, 0, 1);
        chk("bp_y_hold", int'(y), int'(DB));
        cycle(1, 1, DA, DB, 1, 1);
        chk("bp_resume", int'(gnt_a), 1);

        // A drops after 2 beats while B waits
        cycle(0, 0, DA, DB, 1, 0);
        cycle(1, 0, DA, DB, 1, 1);
        cycle(1, 0, DA, DB, 1, 1);
        cycle(1, 1, DA, DB, 1, 1);
        cycle(0, 1, DA, DB, 1, 1);
        chk("handoff_no_gnt_b", int'(gnt_b), 0);
        cycle(0, 1, DA, DB, 1, 1);
        chk("handoff_gnt_b", int'(gnt_b), 1);
        chk("handoff_sel", int'(sel), 1);

        // Reset mid-stream
        cycle(0, 1, DA, DB, 1, 0);
        chk("pre_rst_valid", int'(y_valid), 1);
        cycle(1, 1, DA, DB, 1, 1);
        chk("post_rst_valid", int'(y_valid), 0);
        chk("post_rst_gnt", int'(gnt_a | gnt_b), 0);
`ifdef MUX_SHARE_ARB_STATS_EN
        chk("post_rst_cnt_a", int'(cnt_a), 0);
        chk("post_rst_cnt_b", int'(cnt_b), 0);
`endif

        // Randomized traffic
        ra = 1'b0; rb = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(3) == 0) ra = ~ra;
            if ($urandom_range(3) == 0) rb = ~rb;
            cycle(ra, rb, WIDTH'($urandom), WIDTH'($urandom),
                  ($urandom_range(9) < 7), ($urandom_range(299) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
